// File: rtl/dcache_refill_unit_if.sv
// dcache_refill_unit_if: groups the cache-side miss/refill signals and the five AXI-style channels.
// Latency: none, this is wiring only.
// Backpressure: AwReady/WReady/ArReady stall requests, RReady/BReady gate responses.
//
// Ports (signal names use the refill unit's point of view; In = into the unit):
//   cache side : MissReqIn/MissAddrIn/DirtyIn/VictimAddrIn/VictimDataIn,
//                MissAckOut, RefillValidOut/RefillBeatIdxOut/RefillDataOut,
//                RefillDoneOut, ErrOut
//   AXI side   : Ar*, R*, Aw*, W*, B* channels
// Modports: master = the refill unit (drives AXI requests), slave = the cache plus memory side.
interface dcache_refill_unit_if #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int LINE_BEATS = 4
);
    // Cache side
    logic                         MissReqIn;
    logic [ADDR_W-1:0]            MissAddrIn;
    logic                         DirtyIn;
    logic [ADDR_W-1:0]            VictimAddrIn;
    logic [DATA_W*LINE_BEATS-1:0] VictimDataIn;
    logic                         MissAckOut;
    logic                         RefillValidOut;
    logic [$clog2(LINE_BEATS)-1:0] RefillBeatIdxOut;
    logic [DATA_W-1:0]            RefillDataOut;
    logic                         RefillDoneOut;
    logic                         ErrOut;

    // Read address / read data
    logic                         ArValid;
    logic                         ArReady;
    logic [ADDR_W-1:0]            ArAddr;
    logic [7:0]                   ArLen;
    logic [1:0]                   ArBurst;
    logic                         RValid;
    logic                         RReady;
    logic [DATA_W-1:0]            RData;
    logic                         RLast;
    logic [1:0]                   RResp;

    // Write address / write data / write response
    logic                         AwValid;
    logic                         AwReady;
    logic [ADDR_W-1:0]            AwAddr;
    logic [7:0]                   AwLen;
    logic                         WValid;
    logic                         WReady;
    logic [DATA_W-1:0]            WData;
    logic                         WLast;
    logic                         BValid;
    logic                         BReady;
    logic [1:0]                   BResp;

    modport master (
        input  MissReqIn, MissAddrIn, DirtyIn, VictimAddrIn, VictimDataIn,
        output MissAckOut, RefillValidOut, RefillBeatIdxOut, RefillDataOut,
        output RefillDoneOut, ErrOut,
        output ArValid, ArAddr, ArLen, ArBurst, input ArReady,
        input  RValid, RData, RLast, RResp, output RReady,
        output AwValid, AwAddr, AwLen, input AwReady,
        output WValid, WData, WLast, input WReady,
        input  BValid, BResp, output BReady
    );

    modport slave (
        output MissReqIn, MissAddrIn, DirtyIn, VictimAddrIn, VictimDataIn,
        input  MissAckOut, RefillValidOut, RefillBeatIdxOut, RefillDataOut,
        input  RefillDoneOut, ErrOut,
        input  ArValid, ArAddr, ArLen, ArBurst, output ArReady,
        output RValid, RData, RLast, RResp, input RReady,
        input  AwValid, AwAddr, AwLen, output AwReady,
        input  WValid, WData, WLast, output WReady,
        output BValid, BResp, input BReady
    );
endinterface

// File: rtl/dcache_refill_unit.sv
// dcache_refill_unit: DCache miss handler - optional dirty-victim write-back, then line refill burst.
// Latency: MissAckOut 1 cycle after request; each refill beat 1 cycle after its R handshake.
// Backpressure: holds each AXI valid/address until ready; one miss outstanding, requests ignored while busy.
//
// Ports: i_clk (rising edge), i_rst_n (async active-low), io_bus (dcache_refill_unit_if.master).
// Optional feature macro: DCACHE_CRITICAL_WORD_FIRST_EN
//   defined   -> WRAP burst starting at the missed beat, critical word returned first
//   undefined -> INCR burst from the line base, beats returned 0..LINE_BEATS-1
// BEAT_BYTES must be >= 2 and LINE_BEATS a power of two >= 2.
module dcache_refill_unit #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int LINE_BEATS = 4,
    parameter int BEAT_BYTES = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    dcache_refill_unit_if.master io_bus
);
    localparam int IDX_W = $clog2(LINE_BEATS);
    localparam int BO_W  = $clog2(BEAT_BYTES);
    localparam int OFF_W = $clog2(LINE_BEATS * BEAT_BYTES);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WB_AW = 3'd1;
    localparam logic [2:0] S_WB_W  = 3'd2;
    localparam logic [2:0] S_WB_B  = 3'd3;
    localparam logic [2:0] S_RD_AR = 3'd4;
    localparam logic [2:0] S_RD_R  = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    localparam logic [7:0]       BURST_LEN = 8'(LINE_BEATS - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(LINE_BEATS - 1);
    localparam logic [IDX_W:0]   RCVD_LAST = (IDX_W+1)'(LINE_BEATS - 1);
    localparam logic [IDX_W:0]   RCVD_FULL = (IDX_W+1)'(LINE_BEATS);

    localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-OFF_W){1'b1}}, {OFF_W{1'b0}}};
    localparam logic [ADDR_W-1:0] BEAT_MASK = {{(ADDR_W-BO_W){1'b1}}, {BO_W{1'b0}}};

`ifdef DCACHE_CRITICAL_WORD_FIRST_EN
    localparam logic [ADDR_W-1:0] RD_MASK  = BEAT_MASK;
    localparam logic [1:0]        RD_BURST = 2'b10;  // WRAP
`else
    localparam logic [ADDR_W-1:0] RD_MASK  = LINE_MASK;
    localparam logic [1:0]        RD_BURST = 2'b01;  // INCR
`endif

    logic [2:0]                        r_state;
    logic [ADDR_W-1:0]                 r_rd_addr;      // already aligned for the AR channel
    logic [ADDR_W-1:0]                 r_victim_addr;  // already line-aligned for the AW channel
    logic [LINE_BEATS-1:0][DATA_W-1:0] r_victim_data;
    logic [IDX_W-1:0]                  r_cnt;          // beat index on W, wrapping line index on R
    logic [IDX_W:0]                    r_rcvd;         // R beats accepted, saturates at LINE_BEATS
    logic                              r_err;
    logic                              r_miss_ack;
    logic                              r_refill_vld;
    logic [IDX_W-1:0]                  r_refill_idx;
    logic [DATA_W-1:0]                 r_refill_data;

    logic [IDX_W-1:0] w_start_idx;
    logic             w_final_beat;
    logic             w_aw_st;
    logic             w_w_st;
    logic             w_b_st;
    logic             w_ar_st;
    logic             w_r_st;

`ifdef DCACHE_CRITICAL_WORD_FIRST_EN
    assign w_start_idx = r_rd_addr[OFF_W-1:BO_W];
`else
    assign w_start_idx = '0;
`endif

    assign w_final_beat = (r_rcvd == RCVD_LAST);

    assign w_aw_st = (r_state == S_WB_AW);
    assign w_w_st  = (r_state == S_WB_W);
    assign w_b_st  = (r_state == S_WB_B);
    assign w_ar_st = (r_state == S_RD_AR);
    assign w_r_st  = (r_state == S_RD_R);

    // AXI request channels: each valid is a pure state decode, so at most one
    // is ever high and each drops the cycle after its handshake moves the FSM on.
    assign io_bus.AwValid = w_aw_st;
    assign io_bus.AwAddr  = r_victim_addr;
    assign io_bus.AwLen   = w_aw_st ? BURST_LEN : 8'd0;

    assign io_bus.WValid  = w_w_st;
    assign io_bus.WData   = w_w_st ? r_victim_data[r_cnt] : '0;
    assign io_bus.WLast   = w_w_st && (r_cnt == LAST_IDX);

    assign io_bus.BReady  = w_b_st;

    assign io_bus.ArValid = w_ar_st;
    assign io_bus.ArAddr  = r_rd_addr;
    assign io_bus.ArLen   = w_ar_st ? BURST_LEN : 8'd0;
    assign io_bus.ArBurst = w_ar_st ? RD_BURST : 2'b00;

    assign io_bus.RReady  = w_r_st;

    // Cache-side outputs
    assign io_bus.MissAckOut       = r_miss_ack;
    assign io_bus.RefillValidOut   = r_refill_vld;
    assign io_bus.RefillBeatIdxOut = r_refill_idx;
    assign io_bus.RefillDataOut    = r_refill_data;
    assign io_bus.RefillDoneOut    = (r_state == S_DONE);
    assign io_bus.ErrOut           = (r_state == S_DONE) && r_err;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_rd_addr     <= '0;
            r_victim_addr <= '0;
            r_victim_data <= '0;
            r_cnt         <= '0;
            r_rcvd        <= '0;
            r_err         <= 1'b0;
            r_miss_ack    <= 1'b0;
            r_refill_vld  <= 1'b0;
            r_refill_idx  <= '0;
            r_refill_data <= '0;
        end else begin
            r_miss_ack   <= 1'b0;
            r_refill_vld <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (io_bus.MissReqIn) begin
                        r_rd_addr     <= io_bus.MissAddrIn & RD_MASK;
                        r_victim_addr <= io_bus.VictimAddrIn & LINE_MASK;
                        r_victim_data <= io_bus.VictimDataIn;
                        r_miss_ack    <= 1'b1;
                        r_state       <= io_bus.DirtyIn ? S_WB_AW : S_RD_AR;
                    end
                end

                S_WB_AW: begin
                    if (io_bus.AwReady) begin
                        r_cnt   <= '0;
                        r_state <= S_WB_W;
                    end
                end

                S_WB_W: begin
                    if (io_bus.WReady) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == LAST_IDX) begin
                            r_state <= S_WB_B;
                        end
                    end
                end

                S_WB_B: begin
                    if (io_bus.BValid) begin
                        if (io_bus.BResp != 2'b00) begin
                            r_err <= 1'b1;
                        end
                        r_state <= S_RD_AR;
                    end
                end

                S_RD_AR: begin
                    if (io_bus.ArReady) begin
                        r_cnt   <= w_start_idx;
                        r_rcvd  <= '0;
                        r_state <= S_RD_R;
                    end
                end

                S_RD_R: begin
                    if (io_bus.RValid) begin
                        // Beats beyond a full line (slave overran without RLast) are
                        // swallowed so they cannot overwrite the line being filled.
                        if (r_rcvd != RCVD_FULL) begin
                            r_refill_vld  <= 1'b1;
                            r_refill_idx  <= r_cnt;
                            r_refill_data <= io_bus.RData;
                            r_cnt         <= r_cnt + 1'b1;
                            r_rcvd        <= r_rcvd + 1'b1;
                        end
                        if (io_bus.RResp != 2'b00) begin
                            r_err <= 1'b1;
                        end
                        // RLast always ends the miss; a mismatch with the expected
                        // beat count in either direction is flagged as an error.
                        if (io_bus.RLast) begin
                            if (!w_final_beat) begin
                                r_err <= 1'b1;
                            end
                            r_state <= S_DONE;
                        end else if (w_final_beat) begin
                            r_err <= 1'b1;
                        end
                    end
                end

                S_DONE: begin
                    r_err   <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule
